// File: rtl/cnn_layer_top.sv
// Single-layer fixed-point CNN sequencer: weight load, valid stride-1 convolution with
// optional ReLU, optional 2x2/stride-2 max pooling, all through one synchronous memory port.
module cnn_layer_top #(
    parameter int WIDTH      = 8,
    parameter int DECIMAL    = 4,
    parameter int MEMADDRBIT = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnn_start,
    input  logic [MEMADDRBIT-1:0] dr,
    input  logic [MEMADDRBIT-1:0] dc,
    input  logic [1:0]            dk,
    input  logic [MEMADDRBIT-1:0] inaddr,
    input  logic [MEMADDRBIT-1:0] waddr,
    input  logic [MEMADDRBIT-1:0] outaddr,
    input  logic [MEMADDRBIT-1:0] mp_outaddr,
    input  logic                  relu,
    input  logic                  maxpooling_or_not,
    input  logic                  checkbram,
    input  logic [MEMADDRBIT-1:0] memaddr_check,
    input  logic [WIDTH-1:0]      mem_out,
    output logic [MEMADDRBIT-1:0] memaddr,
    output logic [WIDTH-1:0]      mem_in,
    output logic                  wea_w,
    output logic [7:0]            cnn_state,
    output logic                  cnn_finish
);
    localparam int ACCW = 2*WIDTH + 4;
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((32'sd1 <<< (WIDTH-1)) - 32'sd1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [MEMADDRBIT-1:0]  A_ONE   = {{(MEMADDRBIT-1){1'b0}}, 1'b1};

    typedef logic [MEMADDRBIT-1:0] addr_t;
    typedef enum logic [2:0] {
        IDLE = 3'd0, LOADW = 3'd1, CONV_RD = 3'd2, CONV_WR = 3'd3,
        POOL_RD = 3'd4, POOL_WR = 3'd5, DONE = 3'd6
    } state_t;

    function automatic logic [WIDTH-1:0] conv_out(input logic signed [ACCW-1:0] acc,
                                                  input logic relu_en);
        logic signed [ACCW-1:0] y;
        logic [WIDTH-1:0]       res;
        y = acc >>> DECIMAL;
        if (relu_en && y[ACCW-1])  res = '0;
        else if (y > SAT_MAX)      res = SAT_MAX[WIDTH-1:0];
        else if (y < SAT_MIN)      res = SAT_MIN[WIDTH-1:0];
        else                       res = y[WIDTH-1:0];
        return res;
    endfunction

    state_t                  state_r, state_nxt;
    logic                    ph_r, ph_nxt;
    logic [3:0]              t_r, t_nxt;
    logic [1:0]              i_r, i_nxt, j_r, j_nxt;
    addr_t                   r_r, r_nxt, c_r, c_nxt;
    logic signed [ACCW-1:0]  acc_r, acc_nxt;
    logic signed [WIDTH-1:0] mx_r, mx_nxt;
    logic signed [WIDTH-1:0] w_r [0:8];
    addr_t                   dr_r, dc_r, inaddr_r, waddr_r, outaddr_r, mpaddr_r;
    logic [1:0]              k_r;
    logic                    relu_r, pool_r;
    addr_t                   memaddr_r, addr_s;
    logic [WIDTH-1:0]        mem_in_r, wr_data_s;
    logic                    wea_r, finish_r, w_ld_s;

    // ph_r toggles address-phase/capture-phase so each read spans exactly two cycles
    logic [3:0]                kk_s;
    logic                      degen_s;
    addr_t                     crows_s, ccols_s, wbase_s;
    logic signed [2*WIDTH-1:0] prod_s;
    assign kk_s    = {2'b00, k_r} * {2'b00, k_r};
    assign degen_s = (k_r == 2'd0) || (addr_t'(k_r) > dr_r) || (addr_t'(k_r) > dc_r);
    assign crows_s = dr_r - addr_t'(k_r) + A_ONE;
    assign ccols_s = dc_r - addr_t'(k_r) + A_ONE;
    assign wbase_s = (state_r == IDLE) ? waddr : waddr_r;
    assign prod_s  = $signed(mem_out) * w_r[t_r];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt;
    end

    // Next-state, counter and accumulator sequencing
    always_comb begin
        state_nxt = state_r;
        ph_nxt    = ph_r;
        t_nxt     = t_r;
        i_nxt     = i_r;
        j_nxt     = j_r;
        r_nxt     = r_r;
        c_nxt     = c_r;
        acc_nxt   = acc_r;
        mx_nxt    = mx_r;
        wr_data_s = mem_in_r;
        w_ld_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (cnn_start) begin
                    state_nxt = LOADW;
                    ph_nxt    = 1'b0;
                    t_nxt     = 4'd0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOADW: begin
                if (degen_s) begin
                    state_nxt = DONE;
                end else if (ph_r == 1'b0) begin
                    ph_nxt = 1'b1;
                end else begin
                    ph_nxt = 1'b0;
                    w_ld_s = 1'b1;
                    if (t_r == kk_s - 4'd1) begin
                        state_nxt = CONV_RD;
                        t_nxt     = 4'd0;
                        i_nxt     = 2'd0;
                        j_nxt     = 2'd0;
                        r_nxt     = '0;
                        c_nxt     = '0;
                        acc_nxt   = '0;
                    end else begin
                        t_nxt = t_r + 4'd1;
                    end
                end
            end
            CONV_RD: begin
                if (ph_r == 1'b0) begin
                    ph_nxt = 1'b1;
                end else begin
                    ph_nxt  = 1'b0;
                    acc_nxt = acc_r + ACCW'(prod_s);
                    if (t_r == kk_s - 4'd1) begin
                        state_nxt = CONV_WR;
                        wr_data_s = conv_out(acc_nxt, relu_r);
                    end else if (j_r == k_r - 2'd1) begin
                        t_nxt = t_r + 4'd1;
                        j_nxt = 2'd0;
                        i_nxt = i_r + 2'd1;
                    end else begin
                        t_nxt = t_r + 4'd1;
                        j_nxt = j_r + 2'd1;
                    end
                end
            end
            CONV_WR: begin
                acc_nxt   = '0;
                t_nxt     = 4'd0;
                i_nxt     = 2'd0;
                j_nxt     = 2'd0;
                state_nxt = CONV_RD;
                if (c_r != ccols_s - A_ONE) begin
                    c_nxt = c_r + A_ONE;
                end else if (r_r != crows_s - A_ONE) begin
                    c_nxt = '0;
                    r_nxt = r_r + A_ONE;
                end else begin
                    c_nxt = '0;
                    r_nxt = '0;
                    // Pooling needs at least one full 2x2 window
                    if (pool_r && crows_s > A_ONE && ccols_s > A_ONE) state_nxt = POOL_RD;
                    else                                               state_nxt = DONE;
                end
            end
            POOL_RD: begin
                if (ph_r == 1'b0) begin
                    ph_nxt = 1'b1;
                end else begin
                    ph_nxt = 1'b0;
                    if (t_r == 4'd0 || $signed(mem_out) > mx_r) mx_nxt = $signed(mem_out);
                    else                                          mx_nxt = mx_r;
                    if (t_r == 4'd3) begin
                        state_nxt = POOL_WR;
                        wr_data_s = mx_nxt;
                    end else begin
                        t_nxt = t_r + 4'd1;
                    end
                end
            end
            POOL_WR: begin
                t_nxt     = 4'd0;
                state_nxt = POOL_RD;
                if (c_r != (ccols_s >> 1) - A_ONE) begin
                    c_nxt = c_r + A_ONE;
                end else if (r_r != (crows_s >> 1) - A_ONE) begin
                    c_nxt = '0;
                    r_nxt = r_r + A_ONE;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory address for the cycle the next state occupies
    always_comb begin
        addr_s = '0;
        case (state_nxt)
            IDLE:    addr_s = checkbram ? memaddr_check : '0;
            LOADW:   addr_s = wbase_s + addr_t'(t_nxt);
            CONV_RD: addr_s = inaddr_r + (r_nxt + addr_t'(i_nxt)) * dc_r + c_nxt + addr_t'(j_nxt);
            CONV_WR: addr_s = outaddr_r + r_nxt * ccols_s + c_nxt;
            POOL_RD: addr_s = outaddr_r + {r_nxt[MEMADDRBIT-2:0], t_nxt[1]} * ccols_s
                              + {c_nxt[MEMADDRBIT-2:0], t_nxt[0]};
            POOL_WR: addr_s = mpaddr_r + r_nxt * (ccols_s >> 1) + c_nxt;
            default: addr_s = '0;
        endcase
    end

    // Counters, accumulator, weights and registered memory-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_r      <= 1'b0;
            t_r       <= 4'd0;
            i_r       <= 2'd0;
            j_r       <= 2'd0;
            r_r       <= '0;
            c_r       <= '0;
            acc_r     <= '0;
            mx_r      <= '0;
            memaddr_r <= '0;
            mem_in_r  <= '0;
            wea_r     <= 1'b0;
            finish_r  <= 1'b0;
            for (int n = 0; n < 9; n++) w_r[n] <= '0;
        end else begin
            ph_r      <= ph_nxt;
            t_r       <= t_nxt;
            i_r       <= i_nxt;
            j_r       <= j_nxt;
            r_r       <= r_nxt;
            c_r       <= c_nxt;
            acc_r     <= acc_nxt;
            mx_r      <= mx_nxt;
            memaddr_r <= addr_s;
            mem_in_r  <= wr_data_s;
            wea_r     <= (state_nxt == CONV_WR) || (state_nxt == POOL_WR);
            finish_r  <= (state_nxt == DONE);
            if (w_ld_s) w_r[t_r] <= mem_out;
        end
    end

    // Layer configuration captured on an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dr_r      <= '0;
            dc_r      <= '0;
            k_r       <= 2'd0;
            inaddr_r  <= '0;
            waddr_r   <= '0;
            outaddr_r <= '0;
            mpaddr_r  <= '0;
            relu_r    <= 1'b0;
            pool_r    <= 1'b0;
        end else if (state_r == IDLE && cnn_start) begin
            dr_r      <= dr;
            dc_r      <= dc;
            k_r       <= dk;
            inaddr_r  <= inaddr;
            waddr_r   <= waddr;
            outaddr_r <= outaddr;
            mpaddr_r  <= mp_outaddr;
            relu_r    <= relu;
            pool_r    <= maxpooling_or_not;
        end
    end

    assign memaddr    = memaddr_r;
    assign mem_in     = mem_in_r;
    assign wea_w      = wea_r;
    assign cnn_finish = finish_r;
    assign cnn_state  = {5'b00000, state_r};
endmodule

// File: tb/tb_cnn_layer_top.sv
// Scoreboard bench for cnn_layer_top: a behavioural memory, an arithmetic reference model
// queuing the expected writes, and a monitor that compares every DUT write against it.
module tb_cnn_layer_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cnn_start = 1'b0;
    logic [19:0] dr = '0, dc = '0, inaddr = '0, waddr = '0, outaddr = '0, mp_outaddr = '0;
    logic [1:0]  dk = '0;
    logic        relu = 1'b0, maxpooling_or_not = 1'b0, checkbram = 1'b0;
    logic [19:0] memaddr_check = '0;
    logic [7:0]  mem_out = '0;
    logic [19:0] memaddr;
    logic [7:0]  mem_in;
    logic        wea_w;
    logic [7:0]  cnn_state;
    logic        cnn_finish;

    logic [7:0]  mem [0:4095];
    logic [27:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [19:0] in_b, w_b, out_b, mp_b;

    cnn_layer_top dut (
        .clk(clk), .rst(rst), .cnn_start(cnn_start), .dr(dr), .dc(dc), .dk(dk),
        .inaddr(inaddr), .waddr(waddr), .outaddr(outaddr), .mp_outaddr(mp_outaddr),
        .relu(relu), .maxpooling_or_not(maxpooling_or_not), .checkbram(checkbram),
        .memaddr_check(memaddr_check), .mem_out(mem_out), .memaddr(memaddr),
        .mem_in(mem_in), .wea_w(wea_w), .cnn_state(cnn_state), .cnn_finish(cnn_finish)
    );

    always #5 clk = ~clk;

    // The 4K array aliases the 20-bit space consistently, so wrapped addresses stay coherent
    always @(posedge clk) begin
        if (wea_w) mem[memaddr[11:0]] <= mem_in;
        mem_out <= mem[memaddr[11:0]];
    end

    always @(negedge clk) begin
        logic [27:0] e;
        if (!rst && wea_w) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%h data=%h", memaddr, mem_in);
            end else begin
                e = exp_q.pop_front();
                if ({memaddr, mem_in} !== e) begin
                    n_fail++;
                    $display("FAIL write actual addr=%h data=%h expected addr=%h data=%h",
                             memaddr, mem_in, e[27:8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int rd_s(input logic [19:0] a);
        logic [7:0] v;
        v = mem[a[11:0]];
        return int'($signed(v));
    endfunction

    // Reference: plain convolution / pooling arithmetic over the bench memory
    task automatic model(input int nr, input int nc, input int k, input bit rl, input bit pl);
        int R, C, acc, y, m;
        int conv [0:63];
        logic [19:0] a;
        if (k == 0 || k > nr || k > nc) return;
        R = nr - k + 1;
        C = nc - k + 1;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                acc = 0;
                for (int i = 0; i < k; i++)
                    for (int j = 0; j < k; j++)
                        acc += rd_s(in_b + 20'((r+i)*nc + c + j)) * rd_s(w_b + 20'(i*k + j));
                y = acc >>> 4;
                if (y > 127)  y = 127;
                if (y < -128) y = -128;
                if (rl && y < 0) y = 0;
                conv[r*C + c] = y;
                a = out_b + 20'(r*C + c);
                exp_q.push_back({a, 8'(y)});
            end
        if (pl && R >= 2 && C >= 2)
            for (int pr = 0; pr < R/2; pr++)
                for (int pc = 0; pc < C/2; pc++) begin
                    m = conv[(2*pr)*C + 2*pc];
                    for (int q = 1; q < 4; q++)
                        if (conv[(2*pr + q/2)*C + 2*pc + q%2] > m) m = conv[(2*pr + q/2)*C + 2*pc + q%2];
                    a = mp_b + 20'(pr*(C/2) + pc);
                    exp_q.push_back({a, 8'(m)});
                end
    endtask

    // mode 0: constant v, 1: ramp 0.., 2: random
    task automatic fill(input logic [19:0] base, input int n, input int mode, input logic [7:0] v);
        logic [19:0] a;
        for (int x = 0; x < n; x++) begin
            a = base + 20'(x);
            mem[a[11:0]] = (mode == 0) ? v : (mode == 1) ? 8'(x) : 8'($urandom_range(0, 255));
        end
    endtask

    task automatic run_layer(input int nr, input int nc, input int k, input bit rl, input bit pl,
                             input bit poke_busy);
        bit seen;
        model(nr, nc, k, rl, pl);
        dr = 20'(nr); dc = 20'(nc); dk = 2'(k); relu = rl; maxpooling_or_not = pl;
        inaddr = in_b; waddr = w_b; outaddr = out_b; mp_outaddr = mp_b;
        cnn_start = 1'b1;
        @(negedge clk);
        cnn_start = 1'b0;
        if (poke_busy) begin
            repeat (5) @(negedge clk);
            outaddr = 20'h00A00; dk = 2'd1; cnn_start = 1'b1;
            @(negedge clk);
            cnn_start = 1'b0; outaddr = out_b; dk = 2'(k);
        end
        seen = 1'b0;
        for (int n = 0; n < 20000 && !seen; n++) begin
            @(negedge clk);
            if (cnn_finish) seen = 1'b1;
        end
        check("finish_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("finish_pulse_low", 32'(cnn_finish), 32'd0);
        check("back_to_idle", 32'(cnn_state), 32'd0);
        check("writes_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bit got;
        in_b = 20'h00100; w_b = 20'h00050; out_b = 20'h00400; mp_b = 20'h00800;
        for (int x = 0; x < 4096; x++) mem[x] = 8'h00;
        #12;
        check("rst_state", 32'(cnn_state), 32'd0);
        check("rst_wea", 32'(wea_w), 32'd0);
        check("rst_finish", 32'(cnn_finish), 32'd0);
        check("rst_memaddr", 32'(memaddr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkbram = 1'b1; memaddr_check = 20'h00123;
        repeat (2) @(negedge clk);
        check("checkbram_addr", 32'(memaddr), 32'h00123);
        check("checkbram_wea", 32'(wea_w), 32'd0);
        checkbram = 1'b0;
        repeat (2) @(negedge clk);
        check("checkbram_off", 32'(memaddr), 32'd0);

        // Reset in the middle of a convolution read
        fill(in_b, 16, 0, 8'h10);
        fill(w_b, 9, 0, 8'h10);
        dr = 20'd4; dc = 20'd4; dk = 2'd3; relu = 1'b0; maxpooling_or_not = 1'b0;
        inaddr = in_b; waddr = w_b; outaddr = out_b; mp_outaddr = mp_b;
        cnn_start = 1'b1;
        @(negedge clk);
        cnn_start = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (cnn_state == 8'd2) got = 1'b1;
        end
        check("reach_conv_rd", 32'(got), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_state", 32'(cnn_state), 32'd0);
        check("midrst_wea", 32'(wea_w), 32'd0);
        check("midrst_finish", 32'(cnn_finish), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Saturation, ReLU and negative saturation on an all-ones map
        run_layer(4, 4, 3, 1'b0, 1'b0, 1'b1);
        fill(w_b, 9, 0, 8'hF0);
        run_layer(4, 4, 3, 1'b1, 1'b0, 1'b0);
        run_layer(4, 4, 3, 1'b0, 1'b0, 1'b0);
        // Identity kernel followed by pooling on a ramp
        fill(in_b, 25, 1, 8'h00);
        fill(w_b, 1, 0, 8'h10);
        run_layer(5, 5, 1, 1'b0, 1'b1, 1'b0);
        // Degenerate geometries: no reads or writes
        run_layer(2, 5, 3, 1'b0, 1'b1, 1'b0);
        run_layer(4, 4, 0, 1'b0, 1'b0, 1'b0);

        for (int it = 0; it < 25; it++) begin
            int nr, nc, k;
            nr = $urandom_range(1, 7);
            nc = $urandom_range(1, 7);
            k  = $urandom_range(0, 3);
            in_b  = ($urandom_range(0, 1) == 0) ? 20'h00100 : 20'hFFFF8;
            out_b = (in_b == 20'h00100 && $urandom_range(0, 1) == 1) ? 20'hFFFFC : 20'h00400;
            fill(in_b, nr*nc, 2, 8'h00);
            fill(w_b, 9, 2, 8'h00);
            if ($urandom_range(0, 1) == 1)
                for (int x = 0; x < 9; x++) mem[12'(w_b) + 12'(x)] = 8'($signed(8'(x)) - 8'sd4);
            run_layer(nr, nc, k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'(nr >= 4 && nc >= 4 && k >= 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
